// File: rtl/alu_operand_stage.sv
// alu_operand_stage
//   Operand/result stage between uart_controller and the ALU. Command words
//   from the UART receive path are queued in a small FIFO, issued to the ALU
//   one at a time, held for SETTLE_CYCLES, and the ALU result/flags are then
//   registered for uart_controller.
//
// Optional feature (macro ALU_STAGE_DROP_CNT_EN):
//   defined   -> adds output drop_count[7:0], a saturating count of pushes
//                dropped because the queue was full (cleared only by reset).
//   undefined -> no port, no counter; drops are silent.
//
// Ports
//   clk              system clock
//   reset            asynchronous active-low reset
//   load_data        command word {A, B, opcode}
//   load_pulse       1-cycle strobe qualifying load_data
//   alu_a/b/op       registered operands/opcode to the ALU
//   alu_result_in    ALU combinational result
//   alu_zero_in      ALU zero flag
//   alu_overflow_in  ALU overflow flag
//   result_out       captured result, held until the next capture
//   zero_out         captured zero flag
//   overflow_out     captured overflow flag
//   result_valid     1-cycle pulse in the first cycle a new result is visible
//   fifo_full        queue holds FIFO_DEPTH entries (registered)
//   fifo_empty       queue holds no entries (registered)
//   busy             FSM is not idle
//   drop_count       (feature only) saturating dropped-push count
module alu_operand_stage #(
  parameter int DATA_W        = 8,
  parameter int OP_W          = 6,
  parameter int FIFO_DEPTH    = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [2*DATA_W+OP_W-1:0]   load_data,
  input  logic                       load_pulse,
  output logic [DATA_W-1:0]          alu_a,
  output logic [DATA_W-1:0]          alu_b,
  output logic [OP_W-1:0]            alu_op,
  input  logic [DATA_W-1:0]          alu_result_in,
  input  logic                       alu_zero_in,
  input  logic                       alu_overflow_in,
  output logic [DATA_W-1:0]          result_out,
  output logic                       zero_out,
  output logic                       overflow_out,
  output logic                       result_valid,
  output logic                       fifo_full,
  output logic                       fifo_empty,
  output logic                       busy
`ifdef ALU_STAGE_DROP_CNT_EN
  ,
  output logic [7:0]                 drop_count
`endif
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_FULL    = CNT_W'(FIFO_DEPTH);
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [OP_W-1:0]   op;
  } cmd_t;

  typedef struct packed {
    logic [DATA_W-1:0] res;
    logic              zero;
    logic              ovf;
  } rsp_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Command FIFO
  // ---------------------------------------------------------------------------
  cmd_t [FIFO_DEPTH-1:0] mem_q;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  fifo_full_q, fifo_full_d;
  logic                  fifo_empty_q, fifo_empty_d;
  logic                  push, pop, drop;

  // A full queue still accepts a push when the head is popped in the same
  // cycle, since the freed slot is reused immediately.
  always_comb begin
    push     = load_pulse && (!fifo_full_q || pop);
    drop     = load_pulse && fifo_full_q && !pop;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = (wr_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // Flags track the next count so they line up with count_q after the edge.
    fifo_full_d  = (count_d == CNT_FULL);
    fifo_empty_d = (count_d == '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      fifo_full_q  <= 1'b0;
      fifo_empty_q <= 1'b1;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      fifo_full_q  <= fifo_full_d;
      fifo_empty_q <= fifo_empty_d;
    end
  end

  // Storage needs no reset: entries are only read once the count covers them.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= cmd_t'(load_data);
  end

  // ---------------------------------------------------------------------------
  // Issue / settle / capture FSM
  // ---------------------------------------------------------------------------
  state_t           state_q, state_d;
  logic [SET_W-1:0] cnt_q, cnt_d;
  cmd_t             cmd_q, cmd_d;
  rsp_t             rsp_q, rsp_d;
  logic             result_valid_q, result_valid_d;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    cmd_d          = cmd_q;
    rsp_d          = rsp_q;
    result_valid_d = 1'b0;
    pop            = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty_q) begin
          pop     = 1'b1;
          cmd_d   = mem_q[rd_ptr_q];
          cnt_d   = '0;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == SETTLE_LAST) state_d = CAPTURE;
      end
      CAPTURE: begin
        rsp_d.res      = alu_result_in;
        rsp_d.zero     = alu_zero_in;
        rsp_d.ovf      = alu_overflow_in;
        result_valid_d = 1'b1;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      cmd_q          <= '0;
      rsp_q          <= '0;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      cmd_q          <= cmd_d;
      rsp_q          <= rsp_d;
      result_valid_q <= result_valid_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Optional dropped-push counter
  // ---------------------------------------------------------------------------
`ifdef ALU_STAGE_DROP_CNT_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != 8'hFF)) drop_cnt_d = drop_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) drop_cnt_q <= 8'd0;
    else        drop_cnt_q <= drop_cnt_d;
  end

  assign drop_count = drop_cnt_q;
`else
  logic unused_drop;
  assign unused_drop = drop;
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign alu_a        = cmd_q.a;
  assign alu_b        = cmd_q.b;
  assign alu_op       = cmd_q.op;
  assign result_out   = rsp_q.res;
  assign zero_out     = rsp_q.zero;
  assign overflow_out = rsp_q.ovf;
  assign result_valid = result_valid_q;
  assign fifo_full    = fifo_full_q;
  assign fifo_empty   = fifo_empty_q;
  assign busy         = (state_q != IDLE);

endmodule
